intirvx_ifetch: RTL and testbench
=================================

# intirvx_ifetch

Instruction fetch stage of the intirvx core. It sits between the decode stage's PC control port and the instruction memory. It accepts fetch addresses from decode, issues in-order requests to memory, and pairs each response with its PC. Results are buffered and delivered to decode through a valid/ready handshake, and a flush discards every fetch already in flight.

## Interface
- XLEN, 32, instruction/data width.
- ALEN, 32, address width.
- DEPTH, 4, maximum number of fetches outstanding plus buffered (power of two, ≥2).

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pc  in  XLEN  fetch address from decode (low ALEN bits used).
- pc_valid  in  1  fetch address valid.
- pc_ready  out  1  fetch address accepted this cycle when high with pc_valid.
- flush  in  1  decode's flush_ifetch; discard everything not yet delivered.
- imem_addr  out  ALEN  memory request address.
- imem_req_valid  out  1  memory request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_rdata  in  XLEN  response instruction word.
- imem_err  in  1  response bus error.
- imem_rsp_valid  in  1  response valid (in order, one per cycle max, no backpressure).
- inst  out  XLEN  fetched instruction to decode.
- inst_pc  out  ALEN  address of inst.
- inst_status  out  1  1 = fault (imem_err or pc[1:0]≠0).
- inst_valid  out  1  inst/inst_pc/inst_status valid.
- inst_ready  in  1  decode accepts instruction.

## Operation
- Credits: credits = DEPTH − inflight − rsp_count. inflight is the number of requests issued but not yet answered, including doomed ones. rsp_count is the response FIFO occupancy.
- Request path is combinational pass-through:
  - imem_req_valid = pc_valid & (credits≠0).
  - imem_addr = pc[ALEN-1:0].
  - pc_ready = imem_req_ready & (credits≠0).
  - A request is issued when pc_valid & pc_ready.
- On issue:
  - {pc, pc[1:0]≠0} is pushed into the in-flight address FIFO (DEPTH entries).
  - inflight increments.
- On imem_rsp_valid:
  - The head of the address FIFO is popped and inflight decrements.
  - If drop_cnt≠0 or flush is high in that cycle, the response is discarded and drop_cnt decrements when non-zero.
  - Otherwise {imem_rdata, head pc, imem_err | head misaligned} is pushed into the response FIFO.
- Output: inst/inst_pc/inst_status are the response FIFO head. inst_valid = rsp_count≠0. The head is popped on inst_valid & inst_ready.
- Flush (single cycle):
  - The response FIFO is emptied.
  - drop_cnt ← inflight minus any response arriving that same cycle.
  - A request issued in the flush cycle belongs to the new stream: it is not dropped and is not counted in drop_cnt.
  - An inst handshake in the flush cycle is ignored: decode has already consumed the word.
- Simultaneous issue, response and pop in one cycle are all legal. Counters use net update, and inflight and rsp_count never exceed DEPTH.
- A response with inflight=0 is a protocol violation. It is ignored, and no counter changes.

## Timing
- Reset values:
  - All counters 0, FIFOs empty.
  - inst_valid=0, inst/inst_pc/inst_status=0.
  - imem_req_valid = pc_valid-derived. During reset credits=DEPTH, but outputs are gated to 0 while rst_n=0.
- Request latency: 0 cycles (pc handshake equals memory request cycle).
- Response to inst_valid: 1 cycle. A response in cycle N gives inst_valid in N+1 when the FIFO was empty.
- Full throughput: one request and one delivery per cycle with a memory latency ≤ DEPTH−1 and inst_ready held high.
- pc_ready drops in the cycle credits reaches 0. It rises in the cycle after a pop, a drop or a delivery frees a slot.
- Reset mid-operation clears all state asynchronously. Responses arriving after reset release are ignored (inflight=0).

## Test plan
- Streaming: 8 sequential pcs 0x1000..0x101C, memory latency 2, inst_ready=1 -> 8 insts in order, inst_pc matching, no bubbles after first, inst_status=0.
- Backpressure: DEPTH=4, inst_ready=0, latency 1 -> exactly 4 requests accepted, then pc_ready=0. Releasing inst_ready delivers 4 in order and re-enables pc_ready.
- Flush: 3 requests in flight and 1 buffered, flush pulse with new pc 0x2000 issued the same cycle -> buffered entry vanishes, next 3 responses dropped, first delivered inst_pc=0x2000.
- Faults: imem_err=1 on the response for 0x1004, and pc=0x1006 issued -> both delivered with inst_status=1, neighbours 0.
- Back-to-back flushes 2 cycles apart with slow memory (latency 4) -> no stale instruction ever delivered, and credits return to DEPTH when idle.
- Async reset asserted with 2 in flight -> inst_valid=0 immediately. After release, late responses are ignored and pc_ready=imem_req_ready.

Source files
------------

// File: rtl/intirvx_ifetch.sv
`default_nettype none
// intirvx_ifetch: in-order instruction fetch stage with credit-limited request issue,
// PC/response pairing, a response buffer toward decode, and single-cycle flush.
module intirvx_ifetch #(
    parameter int XLEN  = 32,
    parameter int ALEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic            flush,
    output logic [ALEN-1:0] imem_addr,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_err,
    input  logic            imem_rsp_valid,
    output logic [XLEN-1:0] inst,
    output logic [ALEN-1:0] inst_pc,
    output logic            inst_status,
    output logic            inst_valid,
    input  logic            inst_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] af_wr_q, af_rd_q;
    logic [PW-1:0] rf_wr_q, rf_rd_q;

    logic [ALEN-1:0] af_pc_q   [DEPTH];
    logic            af_mis_q  [DEPTH];
    logic [XLEN-1:0] rf_data_q [DEPTH];
    logic [ALEN-1:0] rf_pc_q   [DEPTH];
    logic            rf_st_q   [DEPTH];

    logic [CW-1:0] credits;
    logic          has_credit;
    logic          issue;
    logic          rsp_take;
    logic          dropping;
    logic          rf_push;
    logic          rf_pop;

    // Doomed requests still hold a credit until their response returns.
    assign credits        = DEPTH_C - inflight_q - rsp_cnt_q;
    assign has_credit     = rst_n & (credits != '0);
    assign imem_req_valid = pc_valid & has_credit;
    assign pc_ready       = imem_req_ready & has_credit;
    assign imem_addr      = pc[ALEN-1:0];
    assign issue          = pc_valid & pc_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_take = imem_rsp_valid & (inflight_q != '0);
    assign dropping = (drop_q != '0) | flush;
    assign rf_push  = rsp_take & ~dropping;
    assign rf_pop   = inst_valid & inst_ready & ~flush;

    assign inst_valid  = (rsp_cnt_q != '0);
    assign inst        = rf_data_q[rf_rd_q];
    assign inst_pc     = rf_pc_q[rf_rd_q];
    assign inst_status = rf_st_q[rf_rd_q];

    always_comb begin
        inflight_d = inflight_q + CW'(issue) - CW'(rsp_take);
        rsp_cnt_d  = rsp_cnt_q + CW'(rf_push) - CW'(rf_pop);
        drop_d     = drop_q;
        if (flush) begin
            rsp_cnt_d = '0;
            // Only requests issued before this cycle are stale.
            drop_d    = inflight_q - CW'(rsp_take);
        end else if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            rsp_cnt_q  <= '0;
            drop_q     <= '0;
            af_wr_q    <= '0;
            af_rd_q    <= '0;
            rf_wr_q    <= '0;
            rf_rd_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            rsp_cnt_q  <= rsp_cnt_d;
            drop_q     <= drop_d;
            if (issue)    af_wr_q <= af_wr_q + PW'(1);
            if (rsp_take) af_rd_q <= af_rd_q + PW'(1);
            if (rf_push)  rf_wr_q <= rf_wr_q + PW'(1);
            if (flush)
                rf_rd_q <= rf_wr_q;
            else if (rf_pop)
                rf_rd_q <= rf_rd_q + PW'(1);
        end
    end

    // Storage is reset so the delivered fields read as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                af_pc_q[i]   <= '0;
                af_mis_q[i]  <= 1'b0;
                rf_data_q[i] <= '0;
                rf_pc_q[i]   <= '0;
                rf_st_q[i]   <= 1'b0;
            end
        end else begin
            if (issue) begin
                af_pc_q[af_wr_q]  <= pc[ALEN-1:0];
                af_mis_q[af_wr_q] <= (pc[1:0] != 2'b00);
            end
            if (rf_push) begin
                rf_data_q[rf_wr_q] <= imem_rdata;
                rf_pc_q[rf_wr_q]   <= af_pc_q[af_rd_q];
                rf_st_q[rf_wr_q]   <= imem_err | af_mis_q[af_rd_q];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_intirvx_ifetch.sv
`default_nettype none
// Bench for intirvx_ifetch: in-order memory model with fixed latency and an
// expected-instruction queue filled at issue time and drained at delivery.
module tb_intirvx_ifetch;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic [31:0] imem_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        imem_rsp_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_status;
    logic        inst_valid;
    logic        inst_ready;

    always #5 clk = ~clk;

    intirvx_ifetch #(.XLEN(32), .ALEN(32), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .flush          (flush),
        .imem_addr      (imem_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_rdata     (imem_rdata),
        .imem_err       (imem_err),
        .imem_rsp_valid (imem_rsp_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_status    (inst_status),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready)
    );

    typedef struct { logic [31:0] pc; int due; logic err; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; logic st; } exp_t;
    typedef struct { logic pv; logic rr; logic exp_prdy; logic exp_rv; } rq_vec_t;
    typedef struct { logic [31:0] pc; logic err; logic stat; } fv_t;

    mreq_t mem_q[$];
    exp_t  exp_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    lat = 1;
    int    n_deliv = 0;
    int    first_dcyc = -1;
    int    last_dcyc = -1;
    logic [31:0] first_dpc = '0;
    logic  cur_err = 1'b0;
    logic  cur_stat = 1'b0;
    bit    issued;

    function automatic logic [31:0] word_of(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_deliv    = 0;
        first_dcyc = -1;
        last_dcyc  = -1;
        first_dpc  = '0;
    endtask

    // One clock cycle: drive memory response, sample at negedge, advance.
    task automatic step();
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            mreq_t m;
            m = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rdata     = word_of(m.pc);
            imem_err       = m.err;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rdata     = $urandom;
            imem_err       = 1'b0;
        end
        @(negedge clk);
        issued = pc_valid && pc_ready;
        if (flush) exp_q.delete();
        if (inst_valid && inst_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL stale_deliver: unexpected inst_pc %0h", inst_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("deliver", {31'b0, inst_status, inst_pc, inst},
                               {31'b0, e.st, e.pc, e.word});
            end
            if (first_dcyc < 0) begin
                first_dcyc = cyc;
                first_dpc  = inst_pc;
            end
            last_dcyc = cyc;
            n_deliv++;
        end
        if (issued) begin
            mreq_t m;
            exp_t  e;
            chk("req_addr", {imem_req_valid, imem_addr}, {1'b1, pc});
            m.pc = pc; m.due = cyc + lat; m.err = cur_err;
            mem_q.push_back(m);
            e.pc = pc; e.word = word_of(pc); e.st = cur_stat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic stream(logic [31:0] base, int n, int stride);
        int k = 0;
        int b = 0;
        pc_valid = 1'b1;
        while (k < n && b < n * 20 + 50) begin
            pc = base + k * stride;
            step();
            if (issued) k++;
            b++;
        end
        pc_valid = 1'b0;
        chk("stream_issued", k, n);
    endtask

    task automatic drain(int budget);
        int b = 0;
        pc_valid = 1'b0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && b < budget) begin
            step();
            b++;
        end
        chk("drain_empty", exp_q.size() + mem_q.size(), 0);
        repeat (2) step();
        chk("idle_inst_valid", inst_valid, 0);
    endtask

    rq_vec_t rq [4];
    fv_t     fv [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rq = '{'{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1, 1'b0},
               '{1'b1, 1'b0, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1, 1'b1}};
        fv = '{'{32'h1000, 1'b0, 1'b0}, '{32'h1004, 1'b1, 1'b1},
               '{32'h1008, 1'b0, 1'b0}, '{32'h1006, 1'b0, 1'b1},
               '{32'h100C, 1'b0, 1'b0}, '{32'h1011, 1'b1, 1'b1}};

        rst_n = 1'b0; pc = 32'h1000; pc_valid = 1'b1; flush = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rdata = '0;
        imem_err = 1'b0; inst_ready = 1'b1;
        #12;
        chk("rst_outputs", {inst_valid, inst_status, inst_pc, inst}, '0);
        chk("rst_req_gated", {pc_ready, imem_req_valid}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pc_valid = 1'b0;

        // Request path in the idle state
        for (int i = 0; i < 4; i++) begin
            pc_valid = rq[i].pv;
            imem_req_ready = rq[i].rr;
            pc = 32'h4000 + 32'(i * 4);
            #1;
            chk("reqpath", {pc_ready, imem_req_valid, imem_addr},
                           {rq[i].exp_prdy, rq[i].exp_rv, pc});
            pc_valid = 1'b0;
            imem_req_ready = 1'b1;
        end
        step();

        // Streaming, latency 2
        lat = 2; clear_stats();
        stream(32'h1000, 8, 4);
        drain(40);
        chk("stream_count", n_deliv, 8);
        chk("stream_nobubble", last_dcyc - first_dcyc, 7);

        // Backpressure, latency 1
        begin
            int k = 0;
            lat = 1; inst_ready = 1'b0; pc_valid = 1'b1;
            for (int i = 0; i < 12; i++) begin
                pc = 32'h1100 + 32'(k * 4);
                step();
                if (issued) k++;
            end
            chk("bp_accepted", k, DEPTH);
            chk("bp_pc_ready_low", pc_ready, 0);
            pc_valid = 1'b0; inst_ready = 1'b1; clear_stats();
            drain(30);
            chk("bp_delivered", n_deliv, DEPTH);
            chk("bp_pc_ready_back", pc_ready, 1);
        end

        // Flush with 3 in flight and 1 buffered
        lat = 3; inst_ready = 1'b0;
        stream(32'h1200, 4, 4);
        chk("fl_pre_valid", inst_valid, 1);
        begin
            int b = 0;
            clear_stats();
            flush = 1'b1; pc_valid = 1'b1; pc = 32'h2000; inst_ready = 1'b1;
            step();
            flush = 1'b0;
            chk("fl_buffer_gone", inst_valid, 0);
            while (!issued && b < 20) begin
                step();
                b++;
            end
            pc_valid = 1'b0;
            drain(40);
            chk("fl_first_pc", first_dpc, 32'h2000);
            chk("fl_count", n_deliv, 1);
        end

        // Request issued in the flush cycle survives
        lat = 3; clear_stats();
        stream(32'h1300, 1, 4);
        flush = 1'b1; pc_valid = 1'b1; pc = 32'h3000;
        step();
        chk("fl2_issue_in_flush", issued, 1);
        flush = 1'b0; pc_valid = 1'b0;
        drain(40);
        chk("fl2_first_pc", first_dpc, 32'h3000);
        chk("fl2_count", n_deliv, 1);

        // Faults: bus error and misaligned pcs
        lat = 1;
        for (int i = 0; i < 6; i++) begin
            int b = 0;
            cur_err = fv[i].err; cur_stat = fv[i].stat;
            pc_valid = 1'b1; pc = fv[i].pc;
            step();
            while (!issued && b < 20) begin
                step();
                b++;
            end
        end
        pc_valid = 1'b0; cur_err = 1'b0; cur_stat = 1'b0;
        drain(30);

        // Back-to-back flushes with slow memory
        begin
            int k = 0;
            lat = 4; inst_ready = 1'b1;
            for (int i = 0; i < 20; i++) begin
                pc_valid = 1'b1;
                pc = 32'h5000 + 32'(k * 4);
                flush = (i == 5 || i == 7);
                step();
                if (issued) k++;
            end
            flush = 1'b0; pc_valid = 1'b0;
            drain(60);
            k = 0; lat = 1; inst_ready = 1'b0; pc_valid = 1'b1;
            for (int i = 0; i < 10; i++) begin
                pc = 32'h5800 + 32'(k * 4);
                step();
                if (issued) k++;
            end
            chk("bb_credits_idle", k, DEPTH);
            pc_valid = 1'b0; inst_ready = 1'b1;
            drain(30);
        end

        // Asynchronous reset with fetches in flight
        begin
            int b = 0;
            lat = 5; inst_ready = 1'b0;
            stream(32'h6000, 3, 4);
            while (!inst_valid && b < 20) begin
                step();
                b++;
            end
            chk("ar_pre_valid", inst_valid, 1);
            rst_n = 1'b0;
            #1;
            chk("ar_valid_immediate", {inst_valid, inst_status, inst_pc, inst}, '0);
            exp_q.delete();
            repeat (2) step();
            rst_n = 1'b1; inst_ready = 1'b1;
            b = 0;
            while (mem_q.size() != 0 && b < 20) begin
                step();
                chk("ar_late_ignored", inst_valid, 0);
                b++;
            end
            imem_req_ready = 1'b0; #1;
            chk("ar_pc_ready_0", pc_ready, 0);
            imem_req_ready = 1'b1; #1;
            chk("ar_pc_ready_1", pc_ready, 1);
            lat = 2; clear_stats();
            stream(32'h7000, 4, 4);
            drain(30);
            chk("ar_post_count", n_deliv, 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
